// File: rtl/dt_pkg.sv
// Shared definitions for the distance-transform scan scheduler: default
// geometry, FSM state encoding, neighbour window offsets, slot numbers
// and pass encodings.
package dt_pkg;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int ADDR_W = 14;
  localparam int WORD_W = 16;
  localparam int DW     = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ROM_RD,
    S_ROM_WAIT,
    S_PIX,
    S_NB_RD,
    S_NB_LAST,
    S_CALC,
    S_WR,
    S_NEXT,
    S_PASS_SW,
    S_DONE
  } state_t;

  localparam logic PASS_FWD = 1'b0;
  localparam logic PASS_BWD = 1'b1;

  // A neighbour offset is kept as (row delta, column delta) so that the
  // linear offset follows whatever image width the scheduler is built for.
  typedef struct packed {
    int dr;
    int dc;
  } nb_ofs_t;

  // Forward window: upper-left, up, upper-right, left.
  localparam nb_ofs_t FWD_OFS [0:3] = '{
    '{dr: -1, dc: -1},
    '{dr: -1, dc:  0},
    '{dr: -1, dc:  1},
    '{dr:  0, dc: -1}
  };

  // Backward window: right, lower-left, down, lower-right, then the centre.
  localparam nb_ofs_t BWD_OFS [0:4] = '{
    '{dr:  0, dc:  1},
    '{dr:  1, dc: -1},
    '{dr:  1, dc:  0},
    '{dr:  1, dc:  1},
    '{dr:  0, dc:  0}
  };

  localparam logic [2:0] SLOT_NB_LAST = 3'd3;
  localparam logic [2:0] SLOT_CENTRE  = 3'd4;

  function automatic int nb_offset(input nb_ofs_t o, input int img_w);
    return o.dr * img_w + o.dc;
  endfunction

endpackage

// File: rtl/dt_nb_addr_gen.sv
// Neighbour address generator: turns the current pixel index, the pass
// and the window issue index into a result-RAM address, and flags pixels
// on the image border (which never fetch a window).
module dt_nb_addr_gen
  import dt_pkg::*;
#(
  parameter int IMG_W  = dt_pkg::IMG_W,
  parameter int IMG_H  = dt_pkg::IMG_H,
  parameter int ADDR_W = dt_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] p,
  input  logic              pass,
  input  logic [2:0]        idx,
  output logic [ADDR_W-1:0] nb_addr,
  output logic              border
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = ADDR_W - COL_W;

  int ofs;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // Select the linear offset of the neighbour being issued this cycle.
  always_comb begin
    ofs = 0;
    if (pass == PASS_FWD) begin
      case (idx)
        3'd0:    ofs = nb_offset(FWD_OFS[0], IMG_W);
        3'd1:    ofs = nb_offset(FWD_OFS[1], IMG_W);
        3'd2:    ofs = nb_offset(FWD_OFS[2], IMG_W);
        3'd3:    ofs = nb_offset(FWD_OFS[3], IMG_W);
        default: ofs = 0;
      endcase
    end else begin
      case (idx)
        3'd0:    ofs = nb_offset(BWD_OFS[0], IMG_W);
        3'd1:    ofs = nb_offset(BWD_OFS[1], IMG_W);
        3'd2:    ofs = nb_offset(BWD_OFS[2], IMG_W);
        3'd3:    ofs = nb_offset(BWD_OFS[3], IMG_W);
        3'd4:    ofs = nb_offset(BWD_OFS[4], IMG_W);
        default: ofs = 0;
      endcase
    end
  end

  assign nb_addr = p + ADDR_W'(ofs);

  assign col = p[COL_W-1:0];
  assign row = p[ADDR_W-1:COL_W];

  assign border = (col == '0) || (col == COL_W'(IMG_W - 1)) ||
                  (row == '0) || (row == ROW_W'(IMG_H - 1));

endmodule

// File: rtl/dt_scan_scheduler.sv
// Distance-transform scan scheduler. Walks the packed binary image in a
// forward then a reverse raster pass, fetches each object pixel's
// neighbour window from the result RAM, hands it to the min/+1 datapath
// and writes the result back. Owns every ROM and RAM strobe.
// Optional build macro DT_SKIP_BG_WORD_EN: in the backward pass, an
// all-background ROM word is skipped without visiting its pixels.
module dt_scan_scheduler
  import dt_pkg::*;
#(
  parameter int IMG_W  = dt_pkg::IMG_W,
  parameter int IMG_H  = dt_pkg::IMG_H,
  parameter int ADDR_W = dt_pkg::ADDR_W,
  parameter int WORD_W = dt_pkg::WORD_W,
  parameter int DW     = dt_pkg::DW
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 done,
  output logic                                 sti_rd,
  output logic [ADDR_W-$clog2(WORD_W)-1:0]     sti_addr,
  input  logic [WORD_W-1:0]                    sti_di,
  output logic                                 res_rd,
  output logic                                 res_wr,
  output logic [ADDR_W-1:0]                    res_addr,
  input  logic [DW-1:0]                        res_di,
  output logic [DW-1:0]                        res_do,
  output logic                                 dp_load,
  output logic [2:0]                           dp_slot,
  output logic                                 dp_mode,
  output logic                                 dp_go,
  input  logic                                 dp_ack,
  input  logic [DW-1:0]                        dp_result
);

  localparam int BIT_W  = $clog2(WORD_W);
  localparam int ROM_AW = ADDR_W - BIT_W;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);

  state_t state, state_n;

  logic [ADDR_W-1:0] p;
  logic              pass;
  logic [WORD_W-1:0] word;
  logic [2:0]        idx;

  logic [ADDR_W-1:0] nb_addr;
  logic              border;
  logic              pix_bit;
  logic [2:0]        last_idx;
  logic [ROM_AW-1:0] word_idx;
  logic [ADDR_W-1:0] p_inc;

  dt_nb_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_nb_addr_gen (
    .p       (p),
    .pass    (pass),
    .idx     (idx),
    .nb_addr (nb_addr),
    .border  (border)
  );

  assign word_idx = p[ADDR_W-1:BIT_W];
  assign pix_bit  = word[BIT_W'(WORD_W - 1) - p[BIT_W-1:0]];
  assign last_idx = (pass == PASS_FWD) ? SLOT_NB_LAST : SLOT_CENTRE;
  assign p_inc    = p + ADDR_W'(1);
  assign dp_mode  = pass;

  // State register; reset abandons any partial window immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic for the raster walk and window fetch sequence.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:     if (start) state_n = S_ROM_RD;
      S_ROM_RD:   state_n = S_ROM_WAIT;
      S_ROM_WAIT: begin
        state_n = S_PIX;
`ifdef DT_SKIP_BG_WORD_EN
        if (pass == PASS_BWD && sti_di == '0)
          state_n = (word_idx == '0) ? S_DONE : S_ROM_RD;
`endif
      end
      S_PIX: begin
        if (border || !pix_bit) state_n = (pass == PASS_FWD) ? S_WR : S_NEXT;
        else                    state_n = S_NB_RD;
      end
      S_NB_RD:    if (idx == last_idx) state_n = S_NB_LAST;
      S_NB_LAST:  state_n = S_CALC;
      S_CALC:     if (dp_ack) state_n = S_WR;
      S_WR:       state_n = S_NEXT;
      S_NEXT: begin
        if (pass == PASS_FWD) begin
          if (p == LAST_PIX)                state_n = S_PASS_SW;
          else if (p_inc[BIT_W-1:0] == '0)  state_n = S_ROM_RD;
          else                              state_n = S_PIX;
        end else begin
          if (p == '0)                      state_n = S_DONE;
          else if (p[BIT_W-1:0] == '0)      state_n = S_ROM_RD;
          else                              state_n = S_PIX;
        end
      end
      S_PASS_SW:  state_n = S_ROM_RD;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // Pixel index, pass, latched ROM word, window index, write data and go pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p      <= '0;
      pass   <= PASS_FWD;
      word   <= '0;
      idx    <= '0;
      res_do <= '0;
      dp_go  <= 1'b0;
    end else begin
      dp_go <= (state == S_NB_LAST);
      case (state)
        S_IDLE: begin
          if (start) begin
            p    <= '0;
            pass <= PASS_FWD;
          end
        end
        S_ROM_WAIT: begin
          word <= sti_di;
`ifdef DT_SKIP_BG_WORD_EN
          if (pass == PASS_BWD && sti_di == '0 && word_idx != '0)
            p <= p - ADDR_W'(WORD_W);
`endif
        end
        S_PIX: begin
          idx    <= '0;
          res_do <= '0;
        end
        S_NB_RD: idx <= idx + 3'd1;
        S_CALC:  if (dp_ack) res_do <= dp_result;
        S_NEXT: begin
          if (pass == PASS_FWD) begin
            if (p != LAST_PIX) p <= p_inc;
          end else begin
            if (p != '0) p <= p - ADDR_W'(1);
          end
        end
        S_PASS_SW: begin
          pass <= PASS_BWD;
          p    <= LAST_PIX;
        end
        S_DONE: pass <= PASS_FWD;
        default: ;
      endcase
    end
  end

  // Strobes, addresses and load markers decoded from the current state.
  always_comb begin
    done     = 1'b0;
    sti_rd   = 1'b0;
    sti_addr = '0;
    res_rd   = 1'b0;
    res_wr   = 1'b0;
    res_addr = '0;
    dp_load  = 1'b0;
    dp_slot  = '0;
    case (state)
      S_ROM_RD: begin
        sti_rd   = 1'b1;
        sti_addr = word_idx;
      end
      S_NB_RD: begin
        res_rd   = 1'b1;
        res_addr = nb_addr;
        if (idx != 3'd0) begin
          dp_load = 1'b1;
          dp_slot = idx - 3'd1;
        end
      end
      S_NB_LAST: begin
        dp_load = 1'b1;
        dp_slot = idx - 3'd1;
      end
      S_WR: begin
        res_wr   = 1'b1;
        res_addr = p;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
